timer_counter: RTL and testbench

Memory-mapped 32-bit down-counting timer, the device that drives the CPU's TC0_int / TC1_int interrupt inputs.
- Sits on the system bridge behind the CPU data port (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata).
- Instantiated twice at top level: TC0 at 0x7f00, TC1 at 0x7f10.
- Its irq output feeds the CPU HWInt bits directly.

---
 rtl/tc_pkg.sv | 27 ++
 rtl/timer_counter.sv | 125 ++++++++++++
 tb/tb_timer_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// tc_pkg - shared definitions for the memory-mapped timer/counter.
//   State encoding, register word offsets, CTRL bit positions and mode codes.
//   The CPU-side store/width checks use the same offsets.
package tc_pkg;

   typedef enum logic [1:0] {
      TC_IDLE = 2'd0,
      TC_LOAD = 2'd1,
      TC_CNT  = 2'd2,
      TC_INT  = 2'd3
   } tc_state_t;

   // Register word offsets (addr[3:2])
   localparam logic [1:0] TC_CTRL   = 2'd0;
   localparam logic [1:0] TC_PRESET = 2'd1;
   localparam logic [1:0] TC_COUNT  = 2'd2;

   // CTRL bit positions
   localparam int TC_CTRL_EN       = 0;
   localparam int TC_CTRL_MODE_LSB = 1;
   localparam int TC_CTRL_IM       = 3;

   // Mode codes; anything other than RELOAD behaves as one-shot
   localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
   localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// timer_counter - 32-bit down-counting timer with a 16-byte register window.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   addr   : byte address; window match on [31:4], register select on [3:2]
//   we     : write strobe (full-word stores only)
//   wdata  : write data
//   rdata  : combinational read data of the addressed register (0 outside window)
//   irq    : CTRL.IM & irq_flag
// Registers: 0x0 CTRL {IM, MODE[1:0], EN}, 0x4 PRESET, 0x8 COUNT (RO), 0xC reads 0.
module timer_counter
   import tc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   tc_state_t   state, state_nx;
   logic [3:0]  ctrl, ctrl_nx;
   logic [31:0] preset, preset_nx;
   logic [31:0] count, count_nx;
   logic        irq_flag, irq_flag_nx;

   logic        sel;
   logic        wr_acc;
   logic        en;
   logic [1:0]  mode;
   logic        unused_addr;

   assign sel    = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr_acc = we & sel;
   assign en     = ctrl[TC_CTRL_EN];
   assign mode   = ctrl[TC_CTRL_MODE_LSB +: 2];
   assign irq    = ctrl[TC_CTRL_IM] & irq_flag;

   // Byte lanes are meaningless for word-only registers
   assign unused_addr = ^addr[1:0];

   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (addr[3:2])
            TC_CTRL:   rdata = {28'd0, ctrl};
            TC_PRESET: rdata = preset;
            TC_COUNT:  rdata = count;
            default:   rdata = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= TC_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_nx;
         ctrl     <= ctrl_nx;
         preset   <= preset_nx;
         count    <= count_nx;
         irq_flag <= irq_flag_nx;
      end
   end

   // A bus write owns the cycle: the FSM, COUNT and irq_flag all stall so a
   // software update never races a hardware update of the same register.
   always_comb begin
      state_nx    = state;
      ctrl_nx     = ctrl;
      preset_nx   = preset;
      count_nx    = count;
      irq_flag_nx = irq_flag;
      if (wr_acc) begin
         case (addr[3:2])
            TC_CTRL:   ctrl_nx   = wdata[3:0];
            TC_PRESET: preset_nx = wdata;
            default:   ;
         endcase
      end else begin
         case (state)
            TC_IDLE: begin
               if (en) begin
                  state_nx    = TC_LOAD;
                  irq_flag_nx = 1'b0;
               end
            end
            TC_LOAD: begin
               count_nx = preset;
               state_nx = TC_CNT;
            end
            TC_CNT: begin
               if (!en) begin
                  state_nx = TC_IDLE;
               end else if (count > 32'd1) begin
                  count_nx = count - 32'd1;
               end else begin
                  // Covers PRESET=0 too, so COUNT never wraps
                  count_nx    = 32'd0;
                  irq_flag_nx = 1'b1;
                  state_nx    = TC_INT;
               end
            end
            TC_INT: begin
               if (mode == TC_MODE_RELOAD) begin
                  irq_flag_nx = 1'b0;
               end else begin
                  // One-shot: flag stays up until software re-enables
                  ctrl_nx[TC_CTRL_EN] = 1'b0;
               end
               state_nx = TC_IDLE;
            end
            default: state_nx = TC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_cmp;
   int n_bad;

   localparam logic [31:0] A_CTRL   = 32'h7f00;
   localparam logic [31:0] A_PRESET = 32'h7f04;
   localparam logic [31:0] A_COUNT  = 32'h7f08;
   localparam logic [31:0] A_RSVD   = 32'h7f0c;

   timer_counter #(.BASE_ADDR(32'h0000_7f00)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All activity sits at posedge+1
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      wr(A_PRESET, 32'd8);
      wr(A_CTRL, 32'h9);
      repeat (5) step();
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd5) begin n_bad++; $display("FAIL pre_reset_count got=%0d exp=5", d); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      for (int i = 0; i < 4; i++) begin
         rd(32'h7f00 + 32'(i * 4), d);
         n_cmp++;
         if (d !== 32'd0) begin n_bad++; $display("FAIL reset_rdata off=%0d got=%h exp=0", i * 4, d); end
      end
      reset = 1'b1;
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      do_reset();
      wr(A_PRESET, 32'd3);
      wr(A_CTRL, 32'h9);
      step(); // LOAD
      for (int i = 3; i >= 0; i--) begin
         step();
         rd(A_COUNT, d);
         n_cmp++;
         if (d !== 32'(i)) begin n_bad++; $display("FAIL oneshot_count got=%0d exp=%0d", d, i); end
         n_cmp++;
         if (irq !== (i == 0)) begin n_bad++; $display("FAIL oneshot_irq cnt=%0d got=%b exp=%b", i, irq, (i == 0)); end
      end
      step();
      step();
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== 32'h8) begin n_bad++; $display("FAIL oneshot_ctrl got=%h exp=8", d); end
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
      wr(A_CTRL, 32'h9);
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL restart_irq_idle got=%b exp=1", irq); end
      step();
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL restart_irq_clear got=%b exp=0", irq); end
   endtask

   task automatic test_reload();
      logic [31:0] d;
      do_reset();
      wr(A_PRESET, 32'd2);
      wr(A_CTRL, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         step();
         n_cmp++;
         if (irq !== (k >= 4 && ((k - 4) % 5) == 0)) begin
            n_bad++;
            $display("FAIL reload_irq cyc=%0d got=%b exp=%b", k, irq, (k >= 4 && ((k - 4) % 5) == 0));
         end
      end
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== 32'hB) begin n_bad++; $display("FAIL reload_ctrl got=%h exp=b", d); end
   endtask

   task automatic test_mask_pause();
      logic [31:0] d;
      do_reset();
      wr(A_PRESET, 32'd4);
      wr(A_CTRL, 32'h1);
      repeat (7) step(); // LOAD, 4,3,2,1, INT (flag), IDLE
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_irq got=%b exp=0", irq); end
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL mask_count got=%0d exp=0", d); end
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== 32'h0) begin n_bad++; $display("FAIL mask_ctrl got=%h exp=0", d); end
      wr(A_CTRL, 32'h9);
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL unmask_irq got=%b exp=1", irq); end

      do_reset();
      wr(A_PRESET, 32'd4);
      wr(A_CTRL, 32'h1);
      repeat (4) step(); // LOAD, 4, 3, 2
      wr(A_CTRL, 32'h0);
      for (int i = 0; i < 10; i++) begin
         rd(A_COUNT, d);
         n_cmp++;
         if (d !== 32'd2) begin n_bad++; $display("FAIL pause_count cyc=%0d got=%0d exp=2", i, d); end
         step();
      end
      wr(A_CTRL, 32'h1);
      step(); // LOAD
      step();
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd4) begin n_bad++; $display("FAIL resume_reload got=%0d exp=4", d); end
   endtask

   task automatic test_write_decode();
      logic [31:0] d;
      do_reset();
      wr(A_PRESET, 32'd6);
      wr(A_CTRL, 32'h1);
      repeat (4) step(); // LOAD, 6, 5, 4
      wr(A_PRESET, 32'd7);
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd4) begin n_bad++; $display("FAIL wrprio_hold got=%0d exp=4", d); end
      step();
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd3) begin n_bad++; $display("FAIL wrprio_next got=%0d exp=3", d); end
      step();
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd2) begin n_bad++; $display("FAIL wrprio_next2 got=%0d exp=2", d); end
      rd(A_PRESET, d);
      n_cmp++;
      if (d !== 32'd7) begin n_bad++; $display("FAIL preset_rb got=%0d exp=7", d); end
      wr(A_CTRL, 32'h0);
      step(); // CNT -> IDLE, COUNT frozen at 2
      wr(A_COUNT, 32'h55);
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd2) begin n_bad++; $display("FAIL count_ro got=%0d exp=2", d); end
      wr(32'h7f20, 32'hF);
      wr(32'h7f24, 32'h99);
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== 32'h0) begin n_bad++; $display("FAIL other_win_ctrl got=%h exp=0", d); end
      rd(A_PRESET, d);
      n_cmp++;
      if (d !== 32'd7) begin n_bad++; $display("FAIL other_win_preset got=%0d exp=7", d); end
      wr(A_RSVD, 32'hFFFF_FFFF);
      rd(A_RSVD, d);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL rsvd_read got=%h exp=0", d); end
      rd(32'h7f14, d);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL outside_read got=%h exp=0", d); end
   endtask

   task automatic test_preset_zero();
      logic [31:0] d;
      logic        exp_irq;
      do_reset();
      wr(A_CTRL, 32'h9);
      for (int k = 1; k <= 3; k++) begin
         step();
         exp_irq = (k == 3);
         n_cmp++;
         if (irq !== exp_irq) begin n_bad++; $display("FAIL pz_irq cyc=%0d got=%b exp=%b", k, irq, exp_irq); end
         rd(A_COUNT, d);
         n_cmp++;
         if (d !== 32'd0) begin n_bad++; $display("FAIL pz_count cyc=%0d got=%0d exp=0", k, d); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      addr  = 32'd0;
      we    = 1'b0;
      wdata = 32'd0;
      step();
      reset = 1'b1;
      test_reset();
      test_oneshot();
      test_reload();
      test_mask_pause();
      test_write_decode();
      test_preset_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
